// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Slide-switch conditioning stage ahead of the priority
//                encoder. Brings the raw switch bus into the clk domain with
//                a two-flop synchroniser, debounces every bit independently
//                with its own stability counter, and produces per-bit
//                rise/fall pulses plus a global change strobe.
//
//  Ports
//    clk     in   1      system clock, rising edge
//    rst     in   1      asynchronous active-high reset
//    sw      in   WIDTH  raw, asynchronous, bouncing switch inputs
//    sw_db   out  WIDTH  debounced vector (bit WIDTH-1 -> encoder en,
//                        bits WIDTH-2..0 -> encoder in)
//    rise    out  WIDTH  one-cycle pulse when a sw_db bit goes 0->1
//    fall    out  WIDTH  one-cycle pulse when a sw_db bit goes 1->0
//    changed out  1      one-cycle pulse when any sw_db bit changes
//
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int WIDTH         = 9,
    parameter int CNT_W         = 20,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // Count value on which the next differing sample is accepted. Because the
    // compare fires at STABLE_CYCLES-1 and clears the counter, it can never
    // wrap for any legal STABLE_CYCLES (1 .. 2^CNT_W-1).
    localparam logic [CNT_W-1:0] c_terminal_cnt = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_differ;    // synchronised sample disagrees with sw_db
    logic [WIDTH-1:0] w_at_term;   // counter sits on its terminal value
    logic [WIDTH-1:0] w_update;    // bits that flip sw_db on this edge

    assign w_differ = r_s2 ^ sw_db;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_at_term[gi] = (r_cnt[gi] == c_terminal_cnt);
        end
    endgenerate

    // A bit that has returned to its old value on the terminal edge has
    // w_differ low, so it is excluded here and takes the counter-clear path.
    assign w_update = w_differ & w_at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            sw_db   <= '0;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            // Plain two-stage synchroniser, nothing between the stages.
            r_s1 <= sw;
            r_s2 <= r_s1;

            // Any agreeing sample restarts the stability window, which is
            // what rejects bounces shorter than STABLE_CYCLES.
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_differ[i] || w_at_term[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end

            sw_db   <= sw_db ^ w_update;
            // On an update edge r_s2 holds the newly accepted level, so it
            // selects the pulse direction directly.
            rise    <= w_update & r_s2;
            fall    <= w_update & ~r_s2;
            changed <= |w_update;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce
//  Description : Self-checking bench for sw_debounce. Two instances run side
//                by side on the same stimulus: one with a 4-cycle filter and
//                one with the minimum 1-cycle filter. A window-based
//                reference model predicts every output each cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] sw  = 9'h000;

    logic [8:0] db4, rise4, fall4;
    logic       chg4;
    logic [8:0] db1, rise1, fall1;
    logic       chg1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sw_debounce #(.WIDTH(9), .CNT_W(8), .STABLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .sw(sw),
        .sw_db(db4), .rise(rise4), .fall(fall4), .changed(chg4)
    );

    sw_debounce #(.WIDTH(9), .CNT_W(4), .STABLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .sw(sw),
        .sw_db(db1), .rise(rise1), .fall(fall1), .changed(chg1)
    );

    // ------------------------------------------------------------------
    // Reference model. Edges are numbered 1,2,... since reset release and
    // samp holds sw as seen at each edge. The value acted on at edge n is
    // sw seen at edge n-2 (zero before the pipe has filled). A bit accepts
    // a new level at edge n when the acted-on values at the last S edges
    // (all after the bit's last update or reset) differ from its level.
    // ------------------------------------------------------------------
    logic [8:0] samp [$];
    logic [8:0] mdb   [2] = '{default: '0};
    logic [8:0] mrise [2] = '{default: '0};
    logic [8:0] mfall [2] = '{default: '0};
    logic       mchg  [2] = '{default: 1'b0};
    int         last_evt [2][9];
    int         m_n;
    logic [8:0] m_upd;
    logic [8:0] m_u;
    bit         m_ok;

    function automatic int filt_len(input int m);
        return (m == 0) ? 4 : 1;
    endfunction

    function automatic logic [8:0] used(input int n);
        if (n >= 3) return samp[n-3];
        return 9'h000;
    endfunction

    function automatic logic [27:0] exp_vec(input int m);
        return {mdb[m], mrise[m], mfall[m], mchg[m]};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            samp.delete();
            for (int m = 0; m < 2; m++) begin
                mdb[m]   = '0;
                mrise[m] = '0;
                mfall[m] = '0;
                mchg[m]  = 1'b0;
                for (int i = 0; i < 9; i++) last_evt[m][i] = 0;
            end
        end else begin
            samp.push_back(sw);
            m_n = samp.size();
            for (int m = 0; m < 2; m++) begin
                m_upd = '0;
                for (int i = 0; i < 9; i++) begin
                    m_ok = 1'b1;
                    for (int j = 0; j < filt_len(m); j++) begin
                        m_u = used(m_n - j);
                        if ((m_n - j) <= last_evt[m][i] || m_u[i] == mdb[m][i]) m_ok = 1'b0;
                    end
                    if (m_ok) begin
                        m_upd[i]       = 1'b1;
                        last_evt[m][i] = m_n;
                    end
                end
                mrise[m] = m_upd & ~mdb[m];
                mfall[m] = m_upd & mdb[m];
                mchg[m]  = |m_upd;
                mdb[m]   = mdb[m] ^ m_upd;
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic settle(input logic [8:0] val, input string tag);
        sw = val;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL %s dut4 got=%h exp=%h", tag, {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            checks++;
            if ({db1, rise1, fall1, chg1} !== exp_vec(1)) begin
                errors++;
                $display("FAIL %s dut1 got=%h exp=%h", tag, {db1, rise1, fall1, chg1}, exp_vec(1));
            end
        end
    endtask

    task automatic test_reset();
        sw = 9'h1FF;
        repeat (2) @(negedge clk);
        checks++;
        if ({db4, rise4, fall4, chg4} !== 28'h0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", {db4, rise4, fall4, chg4});
        end
        for (int pass = 0; pass < 2; pass++) begin
            rst = 1'b0;
            for (int e = 1; e <= 9; e++) begin
                @(negedge clk);
                checks++;
                if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                    errors++;
                    $display("FAIL reset_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
                end
                checks++;
                if ({db1, rise1, fall1, chg1} !== exp_vec(1)) begin
                    errors++;
                    $display("FAIL reset_model dut1 got=%h exp=%h", {db1, rise1, fall1, chg1}, exp_vec(1));
                end
                checks++;
                if (db4 !== ((e >= 6) ? 9'h1FF : 9'h000)) begin
                    errors++;
                    $display("FAIL reset_release_db edge=%0d got=%h exp=%h", e, db4, (e >= 6) ? 9'h1FF : 9'h000);
                end
                checks++;
                if (rise4 !== ((e == 6) ? 9'h1FF : 9'h000) || chg4 !== (e == 6)) begin
                    errors++;
                    $display("FAIL reset_release_pulse edge=%0d rise=%h chg=%b", e, rise4, chg4);
                end
            end
            if (pass == 0) begin
                // Asynchronous assertion while clk is low: outputs must clear
                // before the next rising edge.
                @(negedge clk);
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({db4, rise4, fall4, chg4} !== 28'h0 || {db1, rise1, fall1, chg1} !== 28'h0) begin
                    errors++;
                    $display("FAIL async_reset got4=%h got1=%h exp=0",
                             {db4, rise4, fall4, chg4}, {db1, rise1, fall1, chg1});
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_clean_step();
        settle(9'h000, "step_settle");
        sw = 9'h001;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL step_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            checks++;
            if (db4[0] !== (e >= 6)) begin
                errors++;
                $display("FAIL step_db edge=%0d got=%b exp=%b", e, db4[0], (e >= 6));
            end
            checks++;
            if (rise4[0] !== (e == 6) || chg4 !== (e == 6) || fall4 !== 9'h000) begin
                errors++;
                $display("FAIL step_pulse edge=%0d rise=%h fall=%h chg=%b", e, rise4, fall4, chg4);
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b10101;
        int first_e = 0;
        int rises   = 0;
        for (int p = 4; p >= 0; p--) begin
            sw[3] = pat[p];
            for (int e = 1; e <= ((p == 0) ? 9 : 2); e++) begin
                @(negedge clk);
                checks++;
                if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                    errors++;
                    $display("FAIL bounce_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
                end
                checks++;
                if ({db1, rise1, fall1, chg1} !== exp_vec(1)) begin
                    errors++;
                    $display("FAIL bounce_model dut1 got=%h exp=%h", {db1, rise1, fall1, chg1}, exp_vec(1));
                end
                rises += int'(rise4[3]);
                if (p != 0) begin
                    checks++;
                    if (db4[3] !== 1'b0 || fall4[3] !== 1'b0 || rise4[3] !== 1'b0) begin
                        errors++;
                        $display("FAIL bounce_quiet got db=%b rise=%b fall=%b exp=0", db4[3], rise4[3], fall4[3]);
                    end
                end else if (first_e == 0 && db4[3] === 1'b1) begin
                    first_e = e;
                end
            end
        end
        checks++;
        if (first_e != 6) begin
            errors++;
            $display("FAIL bounce_latency got=%0d exp=6", first_e);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL bounce_rise_count got=%0d exp=1", rises);
        end
    endtask

    task automatic test_simultaneous();
        int first_e = 0;
        int pulses  = 0;
        settle(9'h000, "simul_settle");
        sw = 9'h101;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL simul_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            pulses += int'(chg4);
            if (first_e == 0 && db4 !== 9'h000) begin
                first_e = e;
                checks++;
                if (db4 !== 9'h101 || rise4 !== 9'h101 || chg4 !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_rise got db=%h rise=%h chg=%b exp 101/101/1", db4, rise4, chg4);
                end
            end
        end
        checks++;
        if (first_e != 6 || pulses != 1) begin
            errors++;
            $display("FAIL simul_timing got edge=%0d pulses=%0d exp edge=6 pulses=1", first_e, pulses);
        end
        sw = 9'h001;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL simul_fall_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            checks++;
            if (fall4 !== ((e == 6) ? 9'h100 : 9'h000)) begin
                errors++;
                $display("FAIL simul_fall edge=%0d got=%h exp=%h", e, fall4, (e == 6) ? 9'h100 : 9'h000);
            end
        end
        checks++;
        if (db4 !== 9'h001) begin
            errors++;
            $display("FAIL simul_final got=%h exp=001", db4);
        end
    endtask

    task automatic test_reset_midcount();
        int rises = 0;
        sw = 9'h021;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL midrst_model dut4 got=%h exp=%h", {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            checks++;
            if (db4[5] !== (e >= 6)) begin
                errors++;
                $display("FAIL midrst_db edge=%0d got=%b exp=%b", e, db4[5], (e >= 6));
            end
            rises += int'(rise4[5]);
        end
        checks++;
        if (rises != 1) begin
            errors++;
            $display("FAIL midrst_rise_count got=%0d exp=1", rises);
        end
    endtask

    task automatic test_min_filter();
        sw[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 1) sw[2] = 1'b0;
            checks++;
            if ({db1, rise1, fall1, chg1} !== exp_vec(1)) begin
                errors++;
                $display("FAIL minf_model dut1 got=%h exp=%h", {db1, rise1, fall1, chg1}, exp_vec(1));
            end
            checks++;
            if (db1[2] !== (e == 3) || rise1[2] !== (e == 3) || fall1[2] !== (e == 4)) begin
                errors++;
                $display("FAIL minf_bit2 edge=%0d got db=%b rise=%b fall=%b", e, db1[2], rise1[2], fall1[2]);
            end
            checks++;
            if (db4[2] !== 1'b0 || rise4[2] !== 1'b0) begin
                errors++;
                $display("FAIL minf_dut4_reject edge=%0d got db=%b rise=%b exp 0", e, db4[2], rise4[2]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        int b;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if ({db4, rise4, fall4, chg4} !== exp_vec(0)) begin
                errors++;
                $display("FAIL random c=%0d dut4 got=%h exp=%h", c, {db4, rise4, fall4, chg4}, exp_vec(0));
            end
            checks++;
            if ({db1, rise1, fall1, chg1} !== exp_vec(1)) begin
                errors++;
                $display("FAIL random c=%0d dut1 got=%h exp=%h", c, {db1, rise1, fall1, chg1}, exp_vec(1));
            end
            if (rst) rst = 1'b0;
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                b = int'($urandom_range(0, 8));
                sw[b] = ~sw[b];
            end else if (r == 15) begin
                sw = 9'($urandom);
            end
            if (c == 1000 || c == 2200) #2 rst = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_simultaneous();
        test_reset_midcount();
        test_min_filter();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
